// File: rtl/texto_lcd_valor.sv
// Numeric text overlay for the LCD path. A sequential double-dabble engine
// converts valor to decimal once per frame, and the result is committed
// atomically to a character register. A glyph ROM then turns the current
// pixel position into a 2-cycle-latency letra_ON mask.

// 8x8 glyph ROM with a registered output; address = {char_code, glyph_row}
module ROM_caracteres (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [8:0] dir_i,
    output logic [7:0] dato_o
);

    logic [63:0] glifo;
    logic [7:0]  dato_d;
    logic [7:0]  dato_q;

    // Glyph lookup; row 0 sits in the top byte and bit 7 is the leftmost pixel
    always_comb begin
        glifo = '0;
        case (dir_i[8:3])
            6'o60:   glifo = 64'h3C666E7666663C00; // 0
            6'o61:   glifo = 64'h1838181818187E00; // 1
            6'o62:   glifo = 64'h3C66060C30607E00; // 2
            6'o63:   glifo = 64'h3C66061C06663C00; // 3
            6'o64:   glifo = 64'h0C1C3C6C7E0C0C00; // 4
            6'o65:   glifo = 64'h7E607C0606663C00; // 5
            6'o66:   glifo = 64'h3C607C6666663C00; // 6
            6'o67:   glifo = 64'h7E060C1830303000; // 7
            6'o70:   glifo = 64'h3C66663C66663C00; // 8
            6'o71:   glifo = 64'h3C66663E060C3800; // 9
            6'o55:   glifo = 64'h0000007E00000000; // -
            6'o45:   glifo = 64'h62660C1830664600; // %
            default: glifo = '0;                   // space and unused codes
        endcase
        dato_d = 8'(glifo >> {3'd7 - dir_i[2:0], 3'b000});
    end

    // ROM output register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dato_q <= '0;
        else         dato_q <= dato_d;
    end

    assign dato_o = dato_q;

endmodule

module texto_lcd_valor #(
    parameter int unsigned col_max_pantalla  = 800,
    parameter int unsigned fila_max_pantalla = 480,
    parameter int unsigned N_DIGITOS         = 3,
    parameter int unsigned ANCHO_VALOR       = 7,
    parameter int unsigned potencia_tamanyo  = 2,
    parameter int unsigned COL_INICIO        = 336,
    parameter int unsigned FILA_INICIO       = 96,
    parameter int unsigned SUFIJO_EN         = 1,
    parameter logic [5:0]  SUFIJO            = 6'o45
) (
    input  logic                                   NCLK,
    input  logic                                   RST_n,
    input  logic [ANCHO_VALOR-1:0]                 valor,
    input  logic                                   fin_cuadro,
    input  logic [$clog2(col_max_pantalla-1)-1:0]  columna,
    input  logic [$clog2(fila_max_pantalla-1)-1:0] fila,
    output logic                                   letra_ON,
    output logic                                   ocupado,
    output logic                                   desborde
);

    localparam int unsigned W     = 8 << potencia_tamanyo;
    localparam int unsigned N_CAR = N_DIGITOS + SUFIJO_EN;
    localparam int unsigned NB    = 4 * N_DIGITOS;
    localparam int unsigned CW    = $clog2(ANCHO_VALOR + 1);

    localparam logic [5:0] C_ESPACIO = 6'o40;
    localparam logic [5:0] C_GUION   = 6'o55;
    localparam logic [5:0] C_CERO    = 6'o60;

    typedef enum logic [1:0] {REPOSO, CONVIRTIENDO, CONFIRMAR} estado_t;

    estado_t                estado_q;
    logic                   ocupado_q;
    logic                   desborde_q;
    logic                   ovf_q;
    logic [ANCHO_VALOR-1:0] sr_q;
    logic [NB-1:0]          bcd_q;
    logic [NB-1:0]          bcd_adj;
    logic [CW-1:0]          cnt_q;
    logic [5:0]             disp_q   [N_DIGITOS];
    logic [5:0]             commit_d [N_DIGITOS];
    logic [3:0]             nib;
    logic                   hay_cifra;

    logic [31:0]            dc;
    logic [31:0]            df;
    logic [31:0]            idx;
    logic                   in_field_d;
    logic                   in_field_q;
    logic [5:0]             code;
    logic [8:0]             rom_dir;
    logic [7:0]             rom_dato;
    logic [2:0]             bit_d;
    logic [2:0]             bit_q;
    logic                   letra_q;

    // Double-dabble correction: add 3 to every BCD nibble >= 5 before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < N_DIGITOS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Character image of the finished conversion, leading zeros blanked
    always_comb begin
        hay_cifra = 1'b0;
        nib       = '0;
        for (int unsigned p = 0; p < N_DIGITOS; p++) begin
            commit_d[p] = C_ESPACIO;
            nib         = bcd_q[4*(N_DIGITOS-1-p) +: 4];
            if (ovf_q) begin
                commit_d[p] = C_GUION;
            end else if (nib != 4'd0 || hay_cifra || p == N_DIGITOS - 1) begin
                commit_d[p] = C_CERO + 6'(nib);
                hay_cifra   = 1'b1;
            end
        end
    end

    // Conversion FSM; a carry out of the top BCD nibble means the value does not fit
    always_ff @(posedge NCLK or negedge RST_n) begin
        if (!RST_n) begin
            estado_q   <= REPOSO;
            ocupado_q  <= 1'b0;
            desborde_q <= 1'b0;
            ovf_q      <= 1'b0;
            sr_q       <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            for (int unsigned p = 0; p < N_DIGITOS; p++) begin
                disp_q[p] <= (p == N_DIGITOS - 1) ? C_CERO : C_ESPACIO;
            end
        end else begin
            case (estado_q)
                REPOSO: begin
                    if (fin_cuadro) begin
                        sr_q      <= valor;
                        bcd_q     <= '0;
                        cnt_q     <= '0;
                        ovf_q     <= 1'b0;
                        ocupado_q <= 1'b1;
                        estado_q  <= CONVIRTIENDO;
                    end
                end
                CONVIRTIENDO: begin
                    sr_q  <= sr_q << 1;
                    bcd_q <= {bcd_adj[NB-2:0], sr_q[ANCHO_VALOR-1]};
                    ovf_q <= ovf_q | bcd_adj[NB-1];
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ANCHO_VALOR - 1)) estado_q <= CONFIRMAR;
                end
                CONFIRMAR: begin
                    disp_q     <= commit_d;
                    desborde_q <= ovf_q;
                    ocupado_q  <= 1'b0;
                    estado_q   <= REPOSO;
                end
                default: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= REPOSO;
                end
            endcase
        end
    end

    // Stage 0: field test, character select and ROM address from the pixel position
    always_comb begin
        dc         = 32'(columna) - COL_INICIO;
        df         = 32'(fila) - FILA_INICIO;
        in_field_d = (32'(columna) >= COL_INICIO) && (32'(columna) < COL_INICIO + N_CAR * W) &&
                     (32'(fila) >= FILA_INICIO) && (32'(fila) < FILA_INICIO + W);
        idx        = dc >> (3 + potencia_tamanyo);
        code       = C_ESPACIO;
        for (int unsigned p = 0; p < N_DIGITOS; p++) begin
            if (idx == p) code = disp_q[p];
        end
        if (SUFIJO_EN != 0 && idx == N_DIGITOS) code = SUFIJO;
        rom_dir    = {code, 3'(df >> potencia_tamanyo)};
        bit_d      = 3'(32'd7 - (dc >> potencia_tamanyo));
    end

    ROM_caracteres u_rom (
        .clk_i  (NCLK),
        .rst_ni (RST_n),
        .dir_i  (rom_dir),
        .dato_o (rom_dato)
    );

    // Stages 1 and 2: carry field flag and bit index beside the ROM, then pick the pixel
    always_ff @(posedge NCLK or negedge RST_n) begin
        if (!RST_n) begin
            in_field_q <= 1'b0;
            bit_q      <= '0;
            letra_q    <= 1'b0;
        end else begin
            in_field_q <= in_field_d;
            bit_q      <= bit_d;
            letra_q    <= in_field_q ? rom_dato[bit_q] : 1'b0;
        end
    end

    assign letra_ON = letra_q;
    assign ocupado  = ocupado_q;
    assign desborde = desborde_q;

endmodule

// File: tb/tb_texto_lcd_valor.sv
// Bench for texto_lcd_valor: a default 3-digit instance plus a 2-digit
// instance (so overflow is reachable with a 7-bit value), both checked
// against a decimal/font reference model on streamed pixel coordinates.
module tb_texto_lcd_valor;

    logic       NCLK;
    logic       RST_n;
    logic       fin_cuadro;
    logic [6:0] valor;
    logic [9:0] columna;
    logic [8:0] fila;
    logic       letra_a, ocup_a, desb_a;
    logic       letra_b, ocup_b, desb_b;

    int checks = 0;
    int errors = 0;

    logic [24:0] txt_a;
    logic [24:0] txt_b;

    logic ga_q[$], gb_q[$], ea_q[$], eb_q[$];
    int   cx_q[$], cy_q[$];

    texto_lcd_valor dut_a (
        .NCLK(NCLK), .RST_n(RST_n), .valor(valor), .fin_cuadro(fin_cuadro),
        .columna(columna), .fila(fila),
        .letra_ON(letra_a), .ocupado(ocup_a), .desborde(desb_a)
    );

    texto_lcd_valor #(.N_DIGITOS(2)) dut_b (
        .NCLK(NCLK), .RST_n(RST_n), .valor(valor), .fin_cuadro(fin_cuadro),
        .columna(columna), .fila(fila),
        .letra_ON(letra_b), .ocupado(ocup_b), .desborde(desb_b)
    );

    initial NCLK = 1'b0;
    always #5 NCLK = ~NCLK;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // 8x8 font used on screen
    function automatic logic [7:0] glyph(input logic [5:0] c, input int r);
        logic [7:0] g [8];
        case (c)
            6'o60:   g = '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00};
            6'o61:   g = '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00};
            6'o62:   g = '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00};
            6'o63:   g = '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00};
            6'o64:   g = '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00};
            6'o65:   g = '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00};
            6'o66:   g = '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00};
            6'o67:   g = '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00};
            6'o70:   g = '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00};
            6'o71:   g = '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00};
            6'o55:   g = '{8'h00, 8'h00, 8'h00, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00};
            6'o45:   g = '{8'h62, 8'h66, 8'h0C, 8'h18, 8'h30, 8'h66, 8'h46, 8'h00};
            default: g = '{default: 8'h00};
        endcase
        return g[r];
    endfunction

    // Expected text for value v on an n-digit display: {desborde, char0..char3}
    function automatic logic [24:0] model_txt(input int v, input int n);
        logic [5:0] c [4];
        logic       d;
        logic       lead;
        int         lim, pw, dig;
        c    = '{default: 6'o40};
        lim  = 1;
        for (int i = 0; i < n; i++) lim = lim * 10;
        d    = (v >= lim);
        lead = 1'b1;
        for (int p = 0; p < n; p++) begin
            pw = 1;
            for (int k = 0; k < n - 1 - p; k++) pw = pw * 10;
            dig = (v / pw) % 10;
            if (d) c[p] = 6'o55;
            else if (dig == 0 && lead && p != n - 1) c[p] = 6'o40;
            else begin
                c[p] = 6'(48 + dig);
                lead = 1'b0;
            end
        end
        c[n] = 6'o45;
        return {d, c[0], c[1], c[2], c[3]};
    endfunction

    // Expected letra_ON for a pixel, 32x32 characters starting at (336,96)
    function automatic logic exp_pixel(input int cx, input int cy, input logic [24:0] txt, input int n);
        int         dc, df;
        logic [5:0] code;
        logic [7:0] g;
        dc = cx - 336;
        df = cy - 96;
        if (dc < 0 || dc >= (n + 1) * 32 || df < 0 || df >= 32) return 1'b0;
        code = 6'(txt >> (6 * (3 - dc / 32)));
        g    = glyph(code, df / 4);
        return g[7 - (dc % 32) / 4];
    endfunction

    task automatic set_model(input int v);
        txt_a = model_txt(v, 3);
        txt_b = model_txt(v, 2);
    endtask

    // Stream n coordinates one per cycle and collect outputs two cycles later
    task automatic stream(input int n);
        int cx, cy;
        int ex [6];
        int ey [4];
        ex = '{335, 336, 431, 432, 463, 464};
        ey = '{95, 96, 127, 128};
        ga_q.delete(); gb_q.delete(); ea_q.delete(); eb_q.delete();
        cx_q.delete(); cy_q.delete();
        for (int j = 0; j <= n; j++) begin
            @(negedge NCLK);
            if (j < n) begin
                if ($urandom_range(0, 3) == 0) begin
                    cx = ex[$urandom_range(0, 5)];
                    cy = ey[$urandom_range(0, 3)];
                end else begin
                    cx = int'($urandom_range(328, 472));
                    cy = int'($urandom_range(90, 133));
                end
                columna = 10'(cx);
                fila    = 9'(cy);
                cx_q.push_back(cx);
                cy_q.push_back(cy);
                ea_q.push_back(exp_pixel(cx, cy, txt_a, 3));
                eb_q.push_back(exp_pixel(cx, cy, txt_b, 2));
            end
            @(posedge NCLK);
            #1;
            if (j >= 1) begin
                ga_q.push_back(letra_a);
                gb_q.push_back(letra_b);
            end
        end
    endtask

    // Start one conversion; optional second pulse p2 cycles in. Counts busy
    // cycles and any busy cycle where the two instances disagree or desborde moves
    task automatic convertir(input int v, input int p2, input int v2, output int busy, output int bad);
        @(negedge NCLK);
        valor      = 7'(v);
        fin_cuadro = 1'b1;
        @(negedge NCLK);
        fin_cuadro = 1'b0;
        busy = 0;
        bad  = 0;
        while (ocup_a === 1'b1 && busy < 40) begin
            busy++;
            if (ocup_b !== ocup_a || desb_a !== txt_a[24] || desb_b !== txt_b[24]) bad++;
            if (busy == p2) begin
                valor      = 7'(v2);
                fin_cuadro = 1'b1;
            end else begin
                fin_cuadro = 1'b0;
            end
            @(negedge NCLK);
        end
        fin_cuadro = 1'b0;
    endtask

    task automatic test_reset();
        RST_n = 1'b1; fin_cuadro = 1'b0; valor = '0; columna = '0; fila = '0;
        #2 RST_n = 1'b0;
        #1;
        checks++;
        if ({letra_a, ocup_a, desb_a, letra_b, ocup_b, desb_b} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {letra_a, ocup_a, desb_a, letra_b, ocup_b, desb_b});
        end
        repeat (3) @(negedge NCLK);
        RST_n = 1'b1;
        set_model(0);
        stream(200);
        foreach (ea_q[k]) begin
            checks++;
            if (ga_q[k] !== ea_q[k] || gb_q[k] !== eb_q[k]) begin
                errors++;
                $display("FAIL reset_pixel (%0d,%0d): got a=%b b=%b expected a=%b b=%b",
                         cx_q[k], cy_q[k], ga_q[k], gb_q[k], ea_q[k], eb_q[k]);
            end
        end
    endtask

    task automatic test_conversion();
        int busy, bad;
        convertir(57, -1, 0, busy, bad);
        checks++;
        if (busy != 8 || bad != 0) begin
            errors++;
            $display("FAIL conv57_busy: cycles=%0d side_errs=%0d expected 8 and 0", busy, bad);
        end
        set_model(57);
        checks++;
        if (desb_a !== txt_a[24] || desb_b !== txt_b[24]) begin
            errors++;
            $display("FAIL conv57_desborde: got a=%b b=%b expected a=%b b=%b",
                     desb_a, desb_b, txt_a[24], txt_b[24]);
        end
        stream(200);
        foreach (ea_q[k]) begin
            checks++;
            if (ga_q[k] !== ea_q[k] || gb_q[k] !== eb_q[k]) begin
                errors++;
                $display("FAIL conv57_pixel (%0d,%0d): got a=%b b=%b expected a=%b b=%b",
                         cx_q[k], cy_q[k], ga_q[k], gb_q[k], ea_q[k], eb_q[k]);
            end
        end
    endtask

    // Consecutive frames and overflow boundary values
    task automatic test_sequence();
        int vals [5];
        int busy, bad;
        vals = '{100, 5, 127, 0, 99};
        foreach (vals[i]) begin
            convertir(vals[i], -1, 0, busy, bad);
            checks++;
            if (busy != 8 || bad != 0) begin
                errors++;
                $display("FAIL seq%0d_busy: cycles=%0d side_errs=%0d expected 8 and 0", vals[i], busy, bad);
            end
            set_model(vals[i]);
            checks++;
            if (desb_a !== txt_a[24] || desb_b !== txt_b[24]) begin
                errors++;
                $display("FAIL seq%0d_desborde: got a=%b b=%b expected a=%b b=%b",
                         vals[i], desb_a, desb_b, txt_a[24], txt_b[24]);
            end
            stream(120);
            foreach (ea_q[k]) begin
                checks++;
                if (ga_q[k] !== ea_q[k] || gb_q[k] !== eb_q[k]) begin
                    errors++;
                    $display("FAIL seq%0d_pixel (%0d,%0d): got a=%b b=%b expected a=%b b=%b",
                             vals[i], cx_q[k], cy_q[k], ga_q[k], gb_q[k], ea_q[k], eb_q[k]);
                end
            end
        end
    endtask

    task automatic test_ignored_pulse();
        int busy, bad;
        convertir(42, 3, 99, busy, bad);
        checks++;
        if (busy != 8 || bad != 0) begin
            errors++;
            $display("FAIL ignore_busy: cycles=%0d side_errs=%0d expected 8 and 0", busy, bad);
        end
        repeat (4) @(negedge NCLK);
        checks++;
        if (ocup_a !== 1'b0 || ocup_b !== 1'b0) begin
            errors++;
            $display("FAIL ignore_restart: ocupado a=%b b=%b expected 0 0", ocup_a, ocup_b);
        end
        set_model(42);
        stream(150);
        foreach (ea_q[k]) begin
            checks++;
            if (ga_q[k] !== ea_q[k] || gb_q[k] !== eb_q[k]) begin
                errors++;
                $display("FAIL ignore_pixel (%0d,%0d): got a=%b b=%b expected a=%b b=%b",
                         cx_q[k], cy_q[k], ga_q[k], gb_q[k], ea_q[k], eb_q[k]);
            end
        end
    endtask

    task automatic test_random();
        int v, busy, bad;
        for (int n = 0; n < 12; n++) begin
            v = int'($urandom_range(0, 127));
            convertir(v, -1, 0, busy, bad);
            checks++;
            if (busy != 8 || bad != 0) begin
                errors++;
                $display("FAIL rnd%0d_busy: cycles=%0d side_errs=%0d expected 8 and 0", v, busy, bad);
            end
            set_model(v);
            checks++;
            if (desb_a !== txt_a[24] || desb_b !== txt_b[24]) begin
                errors++;
                $display("FAIL rnd%0d_desborde: got a=%b b=%b expected a=%b b=%b",
                         v, desb_a, desb_b, txt_a[24], txt_b[24]);
            end
            stream(60);
            foreach (ea_q[k]) begin
                checks++;
                if (ga_q[k] !== ea_q[k] || gb_q[k] !== eb_q[k]) begin
                    errors++;
                    $display("FAIL rnd%0d_pixel (%0d,%0d): got a=%b b=%b expected a=%b b=%b",
                             v, cx_q[k], cy_q[k], ga_q[k], gb_q[k], ea_q[k], eb_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_conversion();
        int  busy, bad;
        logic ea, eb;
        convertir(127, -1, 0, busy, bad);
        set_model(127);
        @(negedge NCLK);
        columna = 10'd348;
        fila    = 9'd108;
        @(posedge NCLK); @(posedge NCLK); #1;
        ea = exp_pixel(348, 108, txt_a, 3);
        eb = exp_pixel(348, 108, txt_b, 2);
        checks++;
        if (letra_a !== ea || letra_b !== eb || desb_b !== 1'b1) begin
            errors++;
            $display("FAIL midrst_before: letra a=%b b=%b desborde_b=%b expected %b %b 1",
                     letra_a, letra_b, desb_b, ea, eb);
        end
        @(negedge NCLK);
        valor      = 7'd88;
        fin_cuadro = 1'b1;
        @(negedge NCLK);
        fin_cuadro = 1'b0;
        repeat (2) @(negedge NCLK);
        #2 RST_n = 1'b0;
        #1;
        checks++;
        if ({letra_a, ocup_a, desb_a, letra_b, ocup_b, desb_b} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_clear: got %b expected 000000",
                     {letra_a, ocup_a, desb_a, letra_b, ocup_b, desb_b});
        end
        repeat (2) @(negedge NCLK);
        RST_n = 1'b1;
        set_model(0);
        columna = 10'd336;
        fila    = 9'd96;
        @(posedge NCLK); @(posedge NCLK); #1;
        checks++;
        if (letra_a !== exp_pixel(336, 96, txt_a, 3) || letra_b !== exp_pixel(336, 96, txt_b, 2)) begin
            errors++;
            $display("FAIL midrst_corner: letra a=%b b=%b expected a=%b b=%b", letra_a, letra_b,
                     exp_pixel(336, 96, txt_a, 3), exp_pixel(336, 96, txt_b, 2));
        end
        @(negedge NCLK);
        columna = 10'd335;
        @(posedge NCLK); @(posedge NCLK); #1;
        checks++;
        if (letra_a !== 1'b0 || letra_b !== 1'b0) begin
            errors++;
            $display("FAIL midrst_left_edge: letra a=%b b=%b expected 0 0", letra_a, letra_b);
        end
        stream(150);
        foreach (ea_q[k]) begin
            checks++;
            if (ga_q[k] !== ea_q[k] || gb_q[k] !== eb_q[k]) begin
                errors++;
                $display("FAIL midrst_pixel (%0d,%0d): got a=%b b=%b expected a=%b b=%b",
                         cx_q[k], cy_q[k], ga_q[k], gb_q[k], ea_q[k], eb_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_sequence();
        test_ignored_pulse();
        test_random();
        test_reset_mid_conversion();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
